// File: rtl/mem_access_stage.sv
// Memory-access stage: aligns stores and extends loads over a req/gnt/rvalid data bus, and flags faults.
// Latency: 1 cycle for pass-through and fault ops; 2 or more for stores; 3 or more for loads.
// Backpressure: in_ready is high only in IDLE; the bus stalls via mem_gnt/mem_rvalid, bounded by TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_ALUResult,
    input  logic [31:0] in_WriteData,
    input  logic [2:0]  in_funct3,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [4:0]  in_rd,
    input  logic        in_RegWrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_RegWrite,
    output logic        out_fault
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Latched instruction fields for the bus transaction in flight.
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;

    // Registered bus request fields and writeback outputs.
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_regwrite_q, out_regwrite_d;
    logic        out_fault_q, out_fault_d;

    logic        accept;
    logic        mem_op;
    logic        f3_illegal;
    logic        misaligned;
    logic        acc_fault;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata_shifted;
    logic [31:0] load_value;
    logic        timed_out;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign mem_op   = in_MemRead | in_MemWrite;
    assign timed_out = TO_EN && (cnt_q == CNT_LAST);

    // Decode funct3 legality, alignment and lane placement of the incoming instruction.
    always_comb begin
        f3_illegal = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = in_WriteData;
        case (in_funct3)
            3'b000, 3'b001, 3'b010: f3_illegal = 1'b0;
            3'b100, 3'b101:         f3_illegal = in_MemWrite;
            default:                f3_illegal = 1'b1;
        endcase
        case (in_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << in_ALUResult[1:0];
                wdata_calc = {4{in_WriteData[7:0]}};
            end
            2'b01: begin
                misaligned = in_ALUResult[0];
                be_calc    = 4'b0011 << in_ALUResult[1:0];
                wdata_calc = {2{in_WriteData[15:0]}};
            end
            default: begin
                misaligned = (in_ALUResult[1:0] != 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = in_WriteData;
            end
        endcase
    end

    assign acc_fault = mem_op & (f3_illegal | misaligned);

    // Pick the addressed lane of the returned word and sign- or zero-extend it.
    always_comb begin
        rdata_shifted = mem_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_value = {24'h000000, rdata_shifted[7:0]};
            3'b001:  load_value = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_value = {16'h0000, rdata_shifted[15:0]};
            default: load_value = mem_rdata;
        endcase
    end

    // Next-state and output logic for the IDLE/REQ/RESP handshake.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_lo_d      = addr_lo_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        regwrite_d     = regwrite_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_be_d       = mem_be_q;
        out_valid_d    = 1'b0;
        out_fault_d    = 1'b0;
        out_result_d   = out_result_q;
        out_rd_d       = out_rd_q;
        out_regwrite_d = out_regwrite_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!mem_op) begin
                        out_valid_d    = 1'b1;
                        out_result_d   = in_ALUResult;
                        out_rd_d       = in_rd;
                        out_regwrite_d = in_RegWrite;
                    end else if (acc_fault) begin
                        out_valid_d    = 1'b1;
                        out_fault_d    = 1'b1;
                        out_result_d   = in_ALUResult;
                        out_rd_d       = in_rd;
                        out_regwrite_d = 1'b0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        addr_lo_d   = in_ALUResult[1:0];
                        funct3_d    = in_funct3;
                        rd_d        = in_rd;
                        regwrite_d  = in_RegWrite;
                        mem_we_d    = in_MemWrite;
                        mem_addr_d  = {in_ALUResult[31:2], 2'b00};
                        mem_wdata_d = wdata_calc;
                        mem_be_d    = be_calc;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mem_gnt) begin
                    if (mem_we_q) begin
                        state_d        = S_IDLE;
                        out_valid_d    = 1'b1;
                        out_rd_d       = rd_q;
                        out_regwrite_d = 1'b0;
                    end else begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end
                end else if (timed_out) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    out_fault_d    = 1'b1;
                    out_rd_d       = rd_q;
                    out_regwrite_d = 1'b0;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (mem_rvalid) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    out_result_d   = load_value;
                    out_rd_d       = rd_q;
                    out_regwrite_d = regwrite_q;
                end else if (timed_out) begin
                    state_d        = S_IDLE;
                    out_valid_d    = 1'b1;
                    out_fault_d    = 1'b1;
                    out_rd_d       = rd_q;
                    out_regwrite_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The counter only means something inside a transaction; keep it at zero in IDLE.
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            addr_lo_q      <= 2'b00;
            funct3_q       <= 3'b000;
            rd_q           <= 5'd0;
            regwrite_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_be_q       <= 4'b0000;
            out_valid_q    <= 1'b0;
            out_result_q   <= 32'h0;
            out_rd_q       <= 5'd0;
            out_regwrite_q <= 1'b0;
            out_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_lo_q      <= addr_lo_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            regwrite_q     <= regwrite_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_be_q       <= mem_be_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_rd_q       <= out_rd_d;
            out_regwrite_q <= out_regwrite_d;
            out_fault_q    <= out_fault_d;
        end
    end

    assign mem_req      = (state_q == S_REQ);
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_rd       = out_rd_q;
    assign out_RegWrite = out_regwrite_q;
    assign out_fault    = out_fault_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage placed directly downstream of the execute stage. It takes the ALU result (effective address), the store operand (RD2) and the load/store control of one instruction, then runs a request/grant/response handshake with the data memory. It aligns store data and byte enables, sign- or zero-extends load data, and presents one registered result per instruction to writeback. Misaligned accesses, illegal funct3 values and bus timeouts raise a fault instead of writing a register.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ or RESP before a fault; 0 disables the timeout.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage accepts that instruction this cycle.
- in_ALUResult  in  32  effective address, or pass-through result.
- in_WriteData  in  32  store operand (RD2).
- in_funct3  in  3  instr[14:12].
- in_MemRead / in_MemWrite  in  1 each  load / store; both 0 means pass-through; never both 1.
- in_rd  in  5  destination register.
- in_RegWrite  in  1  instruction writes rd.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- out_valid  out  1  one-cycle result pulse to writeback; writeback always accepts it.
- out_result  out  32  load data or pass-through ALU result.
- out_rd  out  5  destination register.
- out_RegWrite  out  1  forced to 0 on a fault.
- out_fault  out  1  misaligned access, illegal funct3, or timeout.

## Operation
- FSM states: IDLE, REQ, RESP. in_ready = (state==IDLE). Accept = in_valid & in_ready. Accepted fields are latched.
- Accepted pass-through op: next cycle out_valid=1, out_result=in_ALUResult; state stays IDLE.
- Fault check at accept:
  - funct3 LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101. Other values, or 1xx on a store, are illegal.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - On a fault: no bus request; next cycle out_valid=1, out_fault=1, out_RegWrite=0; state stays IDLE.
- Legal memory op: go to REQ. mem_req is 1 throughout REQ, with mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- REQ with mem_gnt=1:
  - Store: go to IDLE; next cycle out_valid=1, out_RegWrite=0.
  - Load: go to RESP.
- RESP with mem_rvalid=1: select the byte or half lane given by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). Next cycle out_valid=1 with that value and the latched rd/RegWrite; state goes to IDLE.
- mem_rvalid outside RESP is ignored.
- Timeout counter (8-bit minimum, or wide enough for TIMEOUT_CYCLES):
  - Cleared on entry to REQ and on entry to RESP; increments every cycle spent in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES with no gnt/rvalid: go to IDLE, mem_req drops; next cycle out_valid=1, out_fault=1, out_RegWrite=0.
- Reset (rst_n=0 at an edge), including mid-transaction: state=IDLE, counter=0, any pending response is dropped.
- Reset values: mem_req=0, mem_we=0, mem_be=0, out_valid=0, out_fault=0, out_RegWrite=0. mem_addr, mem_wdata, out_result and out_rd reset to 0.

## Timing
- Pass-through or fault detected at accept: accepted at edge T, out_valid high during cycle T+1.
- Store: mem_req high from T+1. If gnt arrives in cycle T+k, out_valid is high in T+k+1. Minimum latency 2 cycles.
- Load: gnt at T+k, rvalid at T+m (m>k). out_valid high in T+m+1. Minimum latency 3 cycles.
- in_ready is high during the out_valid cycle, so back-to-back accepts are allowed: sustained throughput is 1 per cycle for pass-through, 1 per 2 cycles for stores.
- out_* fields are valid only while out_valid=1. out_fault and out_valid are single-cycle pulses.
- mem_req never drops before mem_gnt, except on timeout or reset.

## Test plan
- Pass-through: addr=0x1234 → next cycle out_valid=1, out_result=0x1234, no mem_req.
- SB: addr=0x103, data=0xA5 → mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xA5A5A5A5. With gnt after 2 wait cycles, out_valid appears one cycle after gnt with out_RegWrite=0.
- LB/LBU: addr=0x102, rdata=0x0080FF00 → LB gives 0x00000080? No — byte 2=0x80, so LB gives 0xFFFFFF80 and LBU gives 0x00000080. LH at 0x102 gives 0x00000080.
- Faults:
  - LW at 0x102 → no mem_req; out_fault=1, out_RegWrite=0 in T+1.
  - funct3=011 load → same fault response.
- Timeout, TIMEOUT_CYCLES=4, gnt never asserted → mem_req high for exactly 4 cycles, then out_valid=1, out_fault=1.
- Reset in RESP, then a late rvalid → no out_valid is produced and the next instruction is accepted normally.
